game_state_mux: RTL and testbench
=================================

Name: game_state_mux

Overview:
Parametrised N-source selector for the remotely shared game state: ball X/Y and player-2 paddle Y. Sits between the local game logic, the UART receive path (and any further sources) and the drawing pipeline. Adds the following:
- Frame-aligned source switching.
- Per-source hold-last-valid capture.
- Per-source staleness watchdog with automatic fallback to a designated source.

Parameters:
N_SRC, 2, number of state sources (index 0 = local logic, 1 = UART)
X_WIDTH, 11, ball X width
Y_WIDTH, 10, ball Y and paddle Y width
FALLBACK_SRC, 0, source used when the selected source is stale; never marked stale itself
TIMEOUT_FRAMES, 8, frames without src_valid before a source is stale (1..255)
X_BALL_RST, (HOR_PIXELS-BALLSIZE)/2, reset ball X (vga_pkg)
Y_BALL_RST, (VER_PIXELS-BALLSIZE)/2, reset ball Y (vga_pkg)
Y_PAD_RST, (VER_PIXELS-PAD_HEIGHT)/2, reset paddle Y (vga_pkg)

Ports:
- Clocking and reset:
  clk  in  1  system clock
  rst  in  1  synchronous, active-high reset
- Control:
  sw  in  SW_W=$clog2(N_SRC) (min 1)  requested source; asynchronous board switch
  frame_start  in  1  one-cycle pulse at start of vertical blank
- Source inputs:
  src_valid  in  N_SRC  per-source update strobe
  src_x_ball  in  N_SRC*X_WIDTH  packed; source i at [i*X_WIDTH +: X_WIDTH]
  src_y_ball  in  N_SRC*Y_WIDTH  packed, same layout
  src_y_pad  in  N_SRC*Y_WIDTH  packed, same layout
- Outputs:
  x_ball_mux  out  X_WIDTH  selected ball X
  y_ball_mux  out  Y_WIDTH  selected ball Y
  y_player2_mux  out  Y_WIDTH  selected paddle Y
  active_src  out  SW_W  source currently driving the outputs
  src_stale  out  N_SRC  per-source stale flag
  fallback  out  1  1 while active_src is the fallback because the requested source is stale

Behaviour:
- Reset state (all registers, synchronous on rst=1):
  - Outputs: x_ball_mux=X_BALL_RST, y_ball_mux=Y_BALL_RST, y_player2_mux=Y_PAD_RST.
  - Capture registers of every source hold the same reset constants.
  - active_src=FALLBACK_SRC, src_stale=0, fallback=0, frame counters=0.
  - sw synchroniser cleared to FALLBACK_SRC.
  - Reset mid-operation discards any pending switch.
- sw input: passed through a 2-flop synchroniser giving sw_s. A value >= N_SRC is ignored and the previous request is kept.
- Capture: when src_valid[i]=1, capture register i loads that source's three fields in the same edge. Without a strobe, the register holds its last value.
- Output path: outputs are registered from capture[active_src] every cycle. Latency from a src_valid edge to the outputs is 2 clk. Data updates mid-frame are passed through, as today.
- Watchdog, per source i != FALLBACK_SRC:
  - 8-bit counter: cleared on src_valid[i]; otherwise incremented on frame_start; saturates at TIMEOUT_FRAMES.
  - src_stale[i] = (counter == TIMEOUT_FRAMES).
  - If src_valid[i] and frame_start occur in the same cycle, valid wins and the counter goes to 0.
  - src_stale[FALLBACK_SRC] is always 0.
- Selection: the target is sw_s, or FALLBACK_SRC if src_stale[sw_s]=1.
  - active_src loads the target only on a frame_start cycle.
  - fallback loads (src_stale[sw_s] && sw_s!=FALLBACK_SRC) on the same edge.
  - Between frame_start pulses, active_src and fallback are frozen, so a source change never occurs mid-frame.
  - Recovery (valid after stale) clears stale one cycle later. The outputs return to the requested source at the next frame_start.
- Switching does not alter capture contents. The new source's last held value appears 1 clk after the frame_start edge that switches.
- Simultaneous events: a switch and a source going stale on the same frame_start both take effect. The target is evaluated with the pre-edge stale value, so a source that becomes stale on that edge falls back at the following frame_start.

Test Plan:
- Reset: assert rst 2 clk with src_valid=0 -> outputs equal X_BALL_RST/Y_BALL_RST/Y_PAD_RST, active_src=0, src_stale=0, fallback=0.
- Local pass-through: sw=0, src_valid[0] with x=100, y=200, pad=300 -> outputs equal 100/200/300 exactly 2 clk later.
- Frame-aligned switch: sw 0->1, src 1 holding x=500; no frame_start for 50 clk -> outputs stay on source 0 (active_src=0); pulse frame_start -> active_src=1 on that edge, x_ball_mux=500 one clk later.
- Timeout: TIMEOUT_FRAMES=4, sw=1, source 1 silent -> src_stale[1]=1 after the 4th frame_start; fallback=1 and active_src=0 after the 5th.
- Recovery: then pulse src_valid[1] with x=700 -> src_stale[1]=0 next clk; at the next frame_start active_src=1 and fallback=0; x_ball_mux=700 one clk later.
- Collision and mid-operation reset: src_valid[1] in the same cycle as frame_start -> counter reads 0. rst asserted while a switch is pending -> reset values restored and no switch occurs at the next frame_start with sw_s=0.

Source files
------------

// File: rtl/game_state_mux.sv
// rtl/game_state_mux.sv - frame-aligned N-source game state selector with hold-last-valid and staleness fallback
module game_state_mux #(
    parameter int N_SRC          = 2,
    parameter int X_WIDTH        = 11,
    parameter int Y_WIDTH        = 10,
    parameter int FALLBACK_SRC   = 0,
    parameter int TIMEOUT_FRAMES = 8,
    parameter int X_BALL_RST     = (640 - 8) / 2,
    parameter int Y_BALL_RST     = (480 - 8) / 2,
    parameter int Y_PAD_RST      = (480 - 64) / 2,
    parameter int SW_W           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SW_W-1:0]            sw,
    input  logic                       frame_start,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*X_WIDTH-1:0]   src_x_ball,
    input  logic [N_SRC*Y_WIDTH-1:0]   src_y_ball,
    input  logic [N_SRC*Y_WIDTH-1:0]   src_y_pad,
    output logic [X_WIDTH-1:0]         x_ball_mux,
    output logic [Y_WIDTH-1:0]         y_ball_mux,
    output logic [Y_WIDTH-1:0]         y_player2_mux,
    output logic [SW_W-1:0]            active_src,
    output logic [N_SRC-1:0]           src_stale,
    output logic                       fallback
);

    localparam logic [SW_W-1:0]    FB_SEL    = FALLBACK_SRC[SW_W-1:0];
    localparam logic [SW_W:0]      N_SRC_LIM = N_SRC[SW_W:0];
    localparam logic [7:0]         TO_LIM    = TIMEOUT_FRAMES[7:0];
    localparam logic [X_WIDTH-1:0] XB_RST    = X_BALL_RST[X_WIDTH-1:0];
    localparam logic [Y_WIDTH-1:0] YB_RST    = Y_BALL_RST[Y_WIDTH-1:0];
    localparam logic [Y_WIDTH-1:0] YP_RST    = Y_PAD_RST[Y_WIDTH-1:0];

    logic [SW_W-1:0]    sw_meta;
    logic [SW_W-1:0]    sw_s;
    logic [X_WIDTH-1:0] cap_x   [N_SRC];
    logic [Y_WIDTH-1:0] cap_y   [N_SRC];
    logic [Y_WIDTH-1:0] cap_pad [N_SRC];
    logic [7:0]         wd_cnt  [N_SRC];
    logic [SW_W-1:0]    target_src;
    logic               target_fb;

    // Two-flop synchroniser for the board switch; out-of-range requests keep the previous one
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= FB_SEL;
            sw_s    <= FB_SEL;
        end else begin
            sw_meta <= sw;
            if ({1'b0, sw_meta} < N_SRC_LIM) begin
                sw_s <= sw_meta;
            end
        end
    end

    // Hold-last-valid capture of each source's three fields
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (rst) begin
                cap_x[i]   <= XB_RST;
                cap_y[i]   <= YB_RST;
                cap_pad[i] <= YP_RST;
            end else if (src_valid[i]) begin
                cap_x[i]   <= src_x_ball[i*X_WIDTH +: X_WIDTH];
                cap_y[i]   <= src_y_ball[i*Y_WIDTH +: Y_WIDTH];
                cap_pad[i] <= src_y_pad[i*Y_WIDTH +: Y_WIDTH];
            end
        end
    end

    // Per-source frame watchdog; a strobe beats a coincident frame_start, count saturates at the timeout
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (rst || i == FALLBACK_SRC) begin
                wd_cnt[i] <= 8'd0;
            end else if (src_valid[i]) begin
                wd_cnt[i] <= 8'd0;
            end else if (frame_start && wd_cnt[i] != TO_LIM) begin
                wd_cnt[i] <= wd_cnt[i] + 8'd1;
            end
        end
    end

    // Stale flags decoded from the watchdog counters; the fallback source never goes stale
    always_comb begin
        src_stale = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i != FALLBACK_SRC) begin
                src_stale[i] = (wd_cnt[i] == TO_LIM);
            end
        end
    end

    // Next source choice from the synchronised request and its current stale flag
    always_comb begin
        target_src = sw_s;
        target_fb  = 1'b0;
        if (src_stale[sw_s] && sw_s != FB_SEL) begin
            target_src = FB_SEL;
            target_fb  = 1'b1;
        end
    end

    // Source selection only changes at the frame boundary so the picture never tears mid-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            active_src <= FB_SEL;
            fallback   <= 1'b0;
        end else if (frame_start) begin
            active_src <= target_src;
            fallback   <= target_fb;
        end
    end

    // Registered output stage reading the currently active capture slot
    always_ff @(posedge clk) begin
        if (rst) begin
            x_ball_mux    <= XB_RST;
            y_ball_mux    <= YB_RST;
            y_player2_mux <= YP_RST;
        end else begin
            x_ball_mux    <= cap_x[active_src];
            y_ball_mux    <= cap_y[active_src];
            y_player2_mux <= cap_pad[active_src];
        end
    end

endmodule

// File: tb/tb_game_state_mux.sv
// tb/tb_game_state_mux.sv - randomized and directed check of game_state_mux against a cycle model
module tb_game_state_mux;

    localparam int N  = 3;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int TO = 4;
    localparam int XR = (640 - 8) / 2;
    localparam int YR = (480 - 8) / 2;
    localparam int PR = (480 - 64) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    sw;
    logic          frame_start;
    logic [N-1:0]  src_valid;
    logic [N*XW-1:0] src_x_ball;
    logic [N*YW-1:0] src_y_ball;
    logic [N*YW-1:0] src_y_pad;
    logic [XW-1:0] x_ball_mux;
    logic [YW-1:0] y_ball_mux;
    logic [YW-1:0] y_player2_mux;
    logic [1:0]    active_src;
    logic [N-1:0]  src_stale;
    logic          fallback;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_sw1, m_sws, m_act, m_fb, m_x, m_y, m_p;
    int cx[N], cy[N], cp[N], age[N];

    game_state_mux #(
        .N_SRC(N), .X_WIDTH(XW), .Y_WIDTH(YW), .FALLBACK_SRC(0), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .frame_start(frame_start),
        .src_valid(src_valid), .src_x_ball(src_x_ball), .src_y_ball(src_y_ball),
        .src_y_pad(src_y_pad), .x_ball_mux(x_ball_mux), .y_ball_mux(y_ball_mux),
        .y_player2_mux(y_player2_mux), .active_src(active_src),
        .src_stale(src_stale), .fallback(fallback)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input int x, input int y, input int p);
        src_x_ball[i*XW +: XW] = XW'(x);
        src_y_ball[i*YW +: YW] = YW'(y);
        src_y_pad[i*YW +: YW]  = YW'(p);
    endtask

    function automatic bit is_stale(input int i);
        return (i != 0) && (age[i] >= TO);
    endfunction

    // advance the model over one clock edge using the inputs currently applied, then compare
    task automatic tick();
        logic [N-1:0] exp_stale;
        bit st_req;
        if (rst) begin
            m_sw1 = 0; m_sws = 0; m_act = 0; m_fb = 0;
            m_x = XR; m_y = YR; m_p = PR;
            for (int i = 0; i < N; i++) begin
                cx[i] = XR; cy[i] = YR; cp[i] = PR; age[i] = 0;
            end
        end else begin
            m_x = cx[m_act]; m_y = cy[m_act]; m_p = cp[m_act];
            if (frame_start) begin
                st_req = is_stale(m_sws);
                m_act  = st_req ? 0 : m_sws;
                m_fb   = (st_req && m_sws != 0) ? 1 : 0;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i]) begin
                    cx[i] = int'(src_x_ball[i*XW +: XW]);
                    cy[i] = int'(src_y_ball[i*YW +: YW]);
                    cp[i] = int'(src_y_pad[i*YW +: YW]);
                    age[i] = 0;
                end else if (frame_start && age[i] < TO) begin
                    age[i] = age[i] + 1;
                end
            end
            if (m_sw1 < N) m_sws = m_sw1;
            m_sw1 = int'(sw);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_stale[i] = is_stale(i);
        check_val("x_ball", x_ball_mux, m_x);
        check_val("y_ball", y_ball_mux, m_y);
        check_val("y_pad", y_player2_mux, m_p);
        check_val("active_src", active_src, m_act);
        check_val("src_stale", src_stale, exp_stale);
        check_val("fallback", fallback, m_fb);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw = 2'd0; frame_start = 1'b0; src_valid = '0;
        src_x_ball = '0; src_y_ball = '0; src_y_pad = '0;
        for (int i = 0; i < N; i++) begin
            cx[i] = 0; cy[i] = 0; cp[i] = 0; age[i] = 0;
        end
        m_sw1 = 0; m_sws = 0; m_act = 0; m_fb = 0; m_x = 0; m_y = 0; m_p = 0;

        // reset
        tick(); tick();
        rst = 1'b0;
        check_val("rst_x", x_ball_mux, XR);
        check_val("rst_y", y_ball_mux, YR);
        check_val("rst_pad", y_player2_mux, PR);
        check_val("rst_active", active_src, 0);
        check_val("rst_stale", src_stale, 0);
        check_val("rst_fb", fallback, 0);

        // local pass-through, 2 clk latency
        set_src(0, 100, 200, 300); src_valid = 3'b001;
        tick();
        src_valid = '0;
        check_val("lat1_x", x_ball_mux, XR);
        tick();
        check_val("pass_x", x_ball_mux, 100);
        check_val("pass_y", y_ball_mux, 200);
        check_val("pass_pad", y_player2_mux, 300);

        // frame-aligned switch
        set_src(1, 500, 50, 60); src_valid = 3'b010;
        tick();
        src_valid = '0; sw = 2'd1;
        repeat (50) tick();
        check_val("nofs_active", active_src, 0);
        check_val("nofs_x", x_ball_mux, 100);
        frame();
        check_val("sw_active", active_src, 1);
        tick();
        check_val("sw_x", x_ball_mux, 500);

        // timeout of source 1
        src_valid = 3'b010;
        tick();
        src_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            frame();
            if (k == 4) begin
                check_val("to4_stale1", src_stale[1], 1);
                check_val("to4_active", active_src, 1);
                check_val("to4_fb", fallback, 0);
            end
            if (k == 5) begin
                check_val("to5_active", active_src, 0);
                check_val("to5_fb", fallback, 1);
            end
            tick(); tick();
        end
        check_val("to_x", x_ball_mux, 100);

        // recovery
        set_src(1, 700, 70, 80); src_valid = 3'b010;
        tick();
        src_valid = '0;
        check_val("rec_stale1", src_stale[1], 0);
        check_val("rec_hold_active", active_src, 0);
        frame();
        check_val("rec_active", active_src, 1);
        check_val("rec_fb", fallback, 0);
        tick();
        check_val("rec_x", x_ball_mux, 700);

        // valid and frame_start collide: counter restarts from 0
        src_valid = 3'b010; tick(); src_valid = '0;
        repeat (3) begin frame(); tick(); end
        src_valid = 3'b010; frame_start = 1'b1;
        tick();
        src_valid = '0; frame_start = 1'b0;
        repeat (3) begin frame(); tick(); end
        check_val("col_stale_3", src_stale[1], 0);
        frame();
        check_val("col_stale_4", src_stale[1], 1);

        // reset while a switch is pending
        sw = 2'd0;
        repeat (3) tick();
        frame();
        check_val("pre_rst_active", active_src, 0);
        src_valid = 3'b010; tick(); src_valid = '0;
        sw = 2'd1;
        repeat (3) tick();
        rst = 1'b1; sw = 2'd0;
        tick(); tick();
        rst = 1'b0;
        frame();
        check_val("mrst_active", active_src, 0);
        tick();
        check_val("mrst_x", x_ball_mux, XR);

        // out-of-range request is ignored
        sw = 2'd2; repeat (3) tick(); frame();
        check_val("sw2_active", active_src, 2);
        sw = 2'd3; repeat (3) tick(); frame();
        check_val("sw3_active", active_src, 2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 499) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            src_valid[0] = ($urandom_range(0, 3) == 0);
            src_valid[1] = ($urandom_range(0, 19) == 0);
            src_valid[2] = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++)
                set_src(i, $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) sw = 2'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; frame_start = 1'b0; src_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
